// File: rtl/axis_i2c_arbiter.sv
// -----------------------------------------------------------------------------
// axis_i2c_arbiter
//
// Round-robin arbiter that shares one AXI-Stream-fed I2C master between
// NUM_REQ requesters. Each winner forwards exactly one frame word. After that,
// new grants are blocked for HOLD_CYCLES clocks, because the I2C master gives
// no completion indication.
//
// Ports:
//   clk       in   clock
//   arst      in   asynchronous reset, active-high
//   s_tvalid  in   [NUM_REQ]          per-requester valid
//   s_tdata   in   [NUM_REQ*W]        requester i at bits [i*W +: W]
//   s_tready  out  [NUM_REQ]          per-requester ready
//   m_tvalid  out                     to I2C master
//   m_tdata   out  [W]                to I2C master
//   m_tready  in                      from I2C master
//   busy      out                     high while in GRANT or HOLD
//   grant_id  out  [clog2(NUM_REQ)]   current / last granted requester
//
// Optional feature (macro AXIS_I2C_ARB_TUSER_EN):
//   m_tuser       out [clog2(NUM_REQ)]  source tag, grant_id while m_tvalid
//   grant_cnt_ovf out                   sticky starvation flag, cleared by arst
// -----------------------------------------------------------------------------
module axis_i2c_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int AXIS_DATA_WIDTH = 16,
    parameter int HOLD_CYCLES     = 32,
    localparam int IDW            = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               arst,
    input  logic [NUM_REQ-1:0]                 s_tvalid,
    input  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0] s_tdata,
    output logic [NUM_REQ-1:0]                 s_tready,
    output logic                               m_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]         m_tdata,
    input  logic                               m_tready,
    output logic                               busy,
`ifdef AXIS_I2C_ARB_TUSER_EN
    output logic [IDW-1:0]                     grant_id,
    output logic [IDW-1:0]                     m_tuser,
    output logic                               grant_cnt_ovf
`else
    output logic [IDW-1:0]                     grant_id
`endif
);

    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]   sel_s;
    logic             any_req_s;
    logic             hs_s;

    // Round-robin search: first valid requester above grant_q, wrapping.
    always_comb begin
        sel_s     = grant_q;
        any_req_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!any_req_s && s_tvalid[(int'(grant_q) + k) % NUM_REQ]) begin
                any_req_s = 1'b1;
                sel_s     = IDW'((int'(grant_q) + k) % NUM_REQ);
            end else begin
                any_req_s = any_req_s;
            end
        end
    end

    // A beat is forwarded only when the granted requester is valid.
    assign hs_s = (state_q == ST_GRANT) && s_tvalid[grant_q] && m_tready;

    // Next-state logic; grant_id only moves in IDLE so it is stable in GRANT/HOLD.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    grant_d = sel_s;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A granted requester dropping tvalid just keeps us here.
                if (hs_s) begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = CNT_W'(HOLD_CYCLES);
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_HOLD: begin
                // Leaving when the counter reads 1 gives exactly HOLD_CYCLES cycles.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant index and hold counter registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            grant_q <= IDW'(NUM_REQ - 1);
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output mux: only the GRANT state connects a requester to the master.
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = {AXIS_DATA_WIDTH{1'b0}};
        s_tready = {NUM_REQ{1'b0}};
        if (state_q == ST_GRANT) begin
            m_tvalid          = s_tvalid[grant_q];
            m_tdata           = s_tdata[int'(grant_q) * AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
            s_tready[grant_q] = m_tready;
        end else begin
            m_tvalid = 1'b0;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;

`ifdef AXIS_I2C_ARB_TUSER_EN
    localparam int WC = $clog2(NUM_REQ + 2);

    logic [NUM_REQ-1:0][WC-1:0] wait_q;
    logic                       ovf_q;

    assign m_tuser       = m_tvalid ? grant_q : {IDW{1'b0}};
    assign grant_cnt_ovf = ovf_q;

    // Per-requester count of consecutive grant rounds lost while valid (saturating).
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= {WC{1'b0}};
            end
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((state_q == ST_IDLE) && any_req_s) begin
                    if (s_tvalid[i] && (int'(sel_s) != i)) begin
                        if (wait_q[i] != WC'(NUM_REQ + 1)) begin
                            wait_q[i] <= wait_q[i] + WC'(1);
                        end else begin
                            wait_q[i] <= wait_q[i];
                        end
                    end else begin
                        wait_q[i] <= {WC{1'b0}};
                    end
                end else begin
                    wait_q[i] <= wait_q[i];
                end
                if (wait_q[i] > WC'(NUM_REQ)) begin
                    ovf_q <= 1'b1;
                end else begin
                    ovf_q <= ovf_q;
                end
            end
        end
    end
`endif

endmodule
